vec_gather: RTL and testbench
=============================

// Module: vec_gather
// PURPOSE
//  Serial-to-parallel vector assembler feeding the adder_tree vec input.
//  - Accepts one DATA_W word per valid/ready handshake and packs DATA_N words into one vector.
//  - Presents the packed vector with a count of real lanes.
//  - Holds one vector at the output while the next one fills, so a steady stream has no bubbles.
// PARAMETERS
//  DATA_W  16                      word width; must match adder_tree DATA_W
//  DATA_N  32                      lanes per vector, >= 2
//  CNT_W   $clog2(DATA_N+1)        width of the lane count / fill index
// PORTS
//  clk        in   1              clock, rising edge
//  rst_n      in   1              asynchronous reset, active low
//  in_valid   in   1              input word valid
//  in_ready   out  1              block can accept a word
//  in_data    in   DATA_W         input word
//  in_last    in   1              word closes the vector early; remaining lanes are zero-padded
//  out_valid  out  1              out_vec/out_cnt valid
//  out_ready  in   1              consumer accepts the vector
//  out_vec    out  [DATA_N][DATA_W]  packed vector; lane 0 = first word accepted
//  out_cnt    out  CNT_W          number of real lanes, 1..DATA_N
//  stall_cnt  out  32             present only with VEC_GATHER_STALL_CNT_EN
// BEHAVIOUR
//  Reset (async assert, sync release), all values 0:
//   - fill index and fill buffer cleared
//   - state = FILL; in_ready=1 after release
//   - out_valid=0, out_vec=0, out_cnt=0
//  Accept: a word is accepted on a clk edge when in_valid && in_ready.
//   - It is written to lane idx and idx increments.
//  Vector completion:
//   - Occurs when the accepted word makes idx==DATA_N, or is accepted with in_last=1.
//   - On completion, lanes idx+1..DATA_N-1 are forced to 0; out_cnt = idx+1.
//  Output slot free at the completion edge (!out_valid, or out_valid && out_ready):
//   - The vector, including the completing word, loads into out_vec on that edge.
//   - out_valid=1 next cycle (1-cycle latency from last word).
//   - idx is reset to 0; state stays FILL.
//  Output slot busy at the completion edge: state -> HOLD, in_ready=0.
//  HOLD: the first edge with out_ready=1 moves the held vector to out_vec.
//   - out_valid stays 1; idx=0; state -> FILL.
//  Output register:
//   - out_vec/out_cnt are stable while out_valid && !out_ready.
//   - out_valid falls after a handshake unless a new vector loads on the same edge.
//  in_ready = (state==FILL); it is combinational from state only, never from out_ready.
//  in_last with idx==DATA_N-1 is an ordinary full vector (out_cnt=DATA_N).
//  in_data is ignored when in_valid=0. in_last is ignored unless the word is accepted.
//  Reset mid-operation: the partial vector and any held/output vector are discarded; no output fires.
//  Throughput: 1 vector per DATA_N accepted words, provided out_ready keeps up.
// CONFIGURATION
//  VEC_GATHER_STALL_CNT_EN defined:
//   - stall_cnt port exists: a 32-bit counter of cycles spent in HOLD.
//   - Saturates at 2^32-1; cleared by rst_n only.
//  Not defined: no port, no counter logic; behaviour otherwise identical.
// TESTING
//  T1 DATA_N=4:
//   - Stimulus: words 1,2,3,4 back-to-back, out_ready=1.
//   - Required: out_vec={4,3,2,1}, out_cnt=4; out_valid 1 cycle after word 4; in_ready never low.
//  T2 Early close:
//   - Stimulus: words 7,8 with in_last on 8.
//   - Required: out_vec={0,0,8,7}, out_cnt=2; next vector starts at lane 0.
//  T3 Backpressure:
//   - Stimulus: out_ready=0; send 8 words.
//   - Required: first vector held stable; second fills; state HOLD, in_ready=0.
//   - Then out_ready=1: exactly 2 vectors delivered in order with no loss.
//  T4 Reset mid-op:
//   - Stimulus: rst_n low after 2 of 4 words, then release and send 5,6,7,8.
//   - Required: one vector {8,7,6,5}; no vector containing the pre-reset words.
//  T5 Random stream:
//   - Stimulus: 1000 words, random in_valid/out_ready/in_last.
//   - Required: a scoreboard matches every lane and out_cnt; adder_tree sum equals the reference sum.
//  T6 STALL_CNT_EN:
//   - Stimulus: hold out_ready=0 for 10 cycles while in HOLD.
//   - Required: stall_cnt advances by exactly 10.

Source files
------------

// File: rtl/vec_gather.sv
// Serial-to-parallel vector assembler with a double-buffered output register.
// Optional HOLD-cycle counter: define VEC_GATHER_STALL_CNT_EN to add the stall_cnt port.
module vec_gather #(
    parameter int DATA_W = 16,
    parameter int DATA_N = 32,
    parameter int CNT_W  = $clog2(DATA_N + 1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_W-1:0]              in_data,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_N-1:0][DATA_W-1:0]  out_vec,
    output logic [CNT_W-1:0]               out_cnt
`ifdef VEC_GATHER_STALL_CNT_EN
    ,
    output logic [31:0]                    stall_cnt
`endif
);

    typedef enum logic {FILL, HOLD} state_t;

    state_t                           state;
    logic [DATA_N-1:0][DATA_W-1:0]    fill_buf;
    logic [DATA_N-1:0][DATA_W-1:0]    acc_buf;
    logic [DATA_N-1:0][DATA_W-1:0]    done_vec;
    logic [CNT_W-1:0]                 idx;
    logic [CNT_W-1:0]                 hold_cnt;
    logic                             accept;
    logic                             complete;
    logic                             slot_free;

    assign in_ready  = (state == FILL);
    assign accept    = in_valid && in_ready;
    assign complete  = accept && (in_last || (idx == CNT_W'(DATA_N - 1)));
    assign slot_free = !out_valid || out_ready;

    // Lanes above the completing word are masked, so stale buffer contents never leak out.
    always_comb begin
        acc_buf  = fill_buf;
        done_vec = '0;
        for (int unsigned i = 0; i < DATA_N; i++) begin
            if (CNT_W'(i) == idx) begin
                acc_buf[i]  = in_data;
                done_vec[i] = in_data;
            end else if (CNT_W'(i) < idx) begin
                done_vec[i] = fill_buf[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            fill_buf  <= '0;
            idx       <= '0;
            hold_cnt  <= '0;
            out_valid <= 1'b0;
            out_vec   <= '0;
            out_cnt   <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (out_valid && out_ready)
                        out_valid <= 1'b0;
                    if (accept) begin
                        fill_buf <= acc_buf;
                        idx      <= idx + CNT_W'(1);
                    end
                    if (complete) begin
                        idx <= '0;
                        if (slot_free) begin
                            out_vec   <= done_vec;
                            out_cnt   <= idx + CNT_W'(1);
                            out_valid <= 1'b1;
                        end else begin
                            fill_buf <= done_vec;
                            hold_cnt <= idx + CNT_W'(1);
                            state    <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_vec <= fill_buf;
                        out_cnt <= hold_cnt;
                        state   <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

`ifdef VEC_GATHER_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (state == HOLD && stall_cnt != '1)
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_vec_gather.sv
// Self-checking bench for vec_gather (DATA_N=4): vector table, corner sequences, random stream.
module tb_vec_gather;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int CW = $clog2(N + 1);

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [W-1:0]          in_data;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [N-1:0][W-1:0]   out_vec;
    logic [CW-1:0]         out_cnt;
`ifdef VEC_GATHER_STALL_CNT_EN
    logic [31:0]           stall_cnt;
`endif

    vec_gather #(.DATA_W(W), .DATA_N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_vec   (out_vec),
        .out_cnt   (out_cnt)
`ifdef VEC_GATHER_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0][W-1:0] vec;
        logic [CW-1:0]       cnt;
    } exp_t;

    typedef struct {
        logic [N-1:0][W-1:0] w;
        int                  n;
        bit                  last;
        logic [N-1:0][W-1:0] vec;
        logic [CW-1:0]       cnt;
    } rec_t;

    exp_t                sb[$];
    rec_t                tbl[5];
    logic [N-1:0][W-1:0] m_vec;
    int                  m_idx;
    int                  checks = 0;
    int                  errors = 0;
    int                  popped = 0;
    int                  acc_words = 0;
    longint              ref_sum = 0;
    longint              out_sum = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Called just after a negedge with inputs set; accounts for the handshakes of the next posedge.
    task automatic cycle();
        exp_t e;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got vec %0h cnt %0d, required no output", out_vec, out_cnt);
            end else begin
                e = sb.pop_front();
                popped++;
                chk("out_vec", out_vec, e.vec);
                chk("out_cnt", out_cnt, e.cnt);
                for (int i = 0; i < N; i++) out_sum += out_vec[i];
            end
        end else if (out_valid && sb.size() != 0) begin
            chk("hold_stable", out_vec, sb[0].vec);
        end
        if (in_valid && in_ready) begin
            m_vec[m_idx] = in_data;
            m_idx++;
            acc_words++;
            ref_sum += in_data;
            if (m_idx == N || in_last) begin
                e.vec = m_vec;
                e.cnt = CW'(m_idx);
                sb.push_back(e);
                m_vec = '0;
                m_idx = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_word(input logic [W-1:0] d, input logic l);
        bit done = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int t = 0; t < 50 && !done; t++) begin
            done = in_ready;
            cycle();
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no acceptance of %0h, required acceptance", d);
        end
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 50 && (sb.size() != 0 || out_valid); t++) cycle();
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, w0;
        logic [31:0] s0;

        tbl[0] = '{w: {16'd4, 16'd3, 16'd2, 16'd1},    n: 4, last: 0,
                   vec: {16'd4, 16'd3, 16'd2, 16'd1},  cnt: 3'd4};
        tbl[1] = '{w: {16'd0, 16'd0, 16'd8, 16'd7},    n: 2, last: 1,
                   vec: {16'd0, 16'd0, 16'd8, 16'd7},  cnt: 3'd2};
        tbl[2] = '{w: {16'd0, 16'd0, 16'd0, 16'd9},    n: 1, last: 1,
                   vec: {16'd0, 16'd0, 16'd0, 16'd9},  cnt: 3'd1};
        tbl[3] = '{w: {16'd13, 16'd12, 16'd11, 16'd10}, n: 4, last: 1,
                   vec: {16'd13, 16'd12, 16'd11, 16'd10}, cnt: 3'd4};
        tbl[4] = '{w: {16'd0, 16'd7, 16'd6, 16'd5},    n: 3, last: 1,
                   vec: {16'd0, 16'd7, 16'd6, 16'd5},  cnt: 3'd3};

        m_vec     = '0;
        m_idx     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_vec", out_vec, 0);
        chk("rst_out_cnt", out_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);

        // Table: full vectors, early close, single-lane, last on final lane, stale-lane masking
        out_ready = 1'b1;
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < tbl[r].n; k++) begin
                chk("tbl_in_ready", in_ready, 1);
                send_word(tbl[r].w[k], (k == tbl[r].n - 1) && tbl[r].last);
            end
            in_valid = 1'b0;
            in_last  = 1'b0;
            chk("tbl_latency", out_valid, 1);
            chk("tbl_vec", out_vec, tbl[r].vec);
            chk("tbl_cnt", out_cnt, tbl[r].cnt);
            cycle();
            chk("tbl_valid_drop", out_valid, 0);
        end

        // Backpressure: second vector parks in HOLD behind the first
        out_ready = 1'b0;
        p0 = popped;
        for (int k = 0; k < 8; k++) send_word(W'(21 + k), 1'b0);
        in_valid = 1'b0;
        chk("t3_in_ready_hold", in_ready, 0);
        repeat (3) cycle();
        chk("t3_first_vec", out_vec, {16'd24, 16'd23, 16'd22, 16'd21});
        chk("t3_in_ready_still", in_ready, 0);
        drain();
        chk("t3_delivered", popped - p0, 2);

        // Reset mid-vector discards the partial words
        send_word(16'd31, 1'b0);
        send_word(16'd32, 1'b0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        sb.delete();
        m_vec = '0;
        m_idx = 0;
        cycle();
        chk("t4_rst_valid", out_valid, 0);
        chk("t4_rst_vec", out_vec, 0);
        rst_n = 1'b1;
        cycle();
        p0 = popped;
        for (int k = 0; k < 4; k++) send_word(W'(5 + k), 1'b0);
        in_valid = 1'b0;
        chk("t4_vec", out_vec, {16'd8, 16'd7, 16'd6, 16'd5});
        drain();
        repeat (4) cycle();
        chk("t4_delivered", popped - p0, 1);

        // Random stream
        ref_sum = 0;
        out_sum = 0;
        w0 = acc_words;
        for (int c = 0; c < 20000 && (acc_words - w0) < 1000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = W'($urandom);
            in_last   = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            cycle();
        end
        chk("t5_words", acc_words - w0, 1000);
        send_word(16'h0abc, 1'b1);
        drain();
        chk("t5_sum", out_sum, ref_sum);

`ifdef VEC_GATHER_STALL_CNT_EN
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) send_word(W'(40 + k), 1'b0);
        in_valid = 1'b0;
        s0 = stall_cnt;
        repeat (10) cycle();
        chk("t6_stall_delta", stall_cnt - s0, 32'd10);
        drain();
`else
        s0 = '0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
